// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared widths for the FIFO write arbiter (package fifo_arb_pkg)
package fifo_arb_pkg;
  localparam int BCNT_W = 4;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshakes and FIFO write port of the write arbiter
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(parameter int NREQ = 4, parameter int DSIZE = 8);
  localparam int IW = idw(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*DSIZE-1:0] req_data;
  logic wfull;
  logic win;
  logic [DSIZE-1:0] wdata;
  logic [IW-1:0] wid;
  modport master (input req_valid, req_data, wfull, output req_ready, win, wdata, wid);
  modport slave (output req_valid, req_data, wfull, input req_ready, win, wdata, wid);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating-priority picker, first set request after index last wins
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = idw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    // scan from farthest to nearest so the nearest hit after last overrides
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt_idx = IW'((int'(last) + k) % N);
        any = 1'b1;
      end
    end
    gnt_onehot = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of the async FIFO write port, registered win/wdata/wid.
// Define FIFO_ARB_BURST_EN to keep a grant on one requester for up to BURST_LEN beats.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DSIZE = 8,
  parameter int BURST_LEN = 4
) (
  input logic wclk,
  input logic wrst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = idw(NREQ);
  if (NREQ < 2 || NREQ > 16 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_param
    $error("fifo_wr_arbiter: NREQ must be 2..16 and BURST_LEN 1..16");
  end
  logic r_win;
  logic [DSIZE-1:0] r_wdata;
  logic [IW-1:0] r_wid, r_last;
  logic w_load, w_any, w_pany;
  logic [NREQ-1:0] w_onehot, w_ponehot;
  logic [IW-1:0] w_idx, w_pidx;
  rr_pick #(.N(NREQ)) u_pick (
    .req(bus.req_valid),
    .last(r_last),
    .gnt_onehot(w_ponehot),
    .gnt_idx(w_pidx),
    .any(w_pany)
  );
  assign w_load = !r_win || !bus.wfull;
`ifdef FIFO_ARB_BURST_EN
  logic [BCNT_W-1:0] r_bcnt;
  logic r_own;
  logic w_room, w_keep;
  // r_own stops the reset value of last from claiming a burst before any grant
  assign w_room = int'(r_bcnt) < BURST_LEN - 1;
  assign w_keep = r_own && bus.req_valid[r_last] && w_room;
  assign w_idx = w_keep ? r_last : w_pidx;
  assign w_any = w_keep || w_pany;
  assign w_onehot = w_keep ? NREQ'(1) << r_last : w_ponehot;
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      r_bcnt <= '0;
      r_own <= 1'b0;
    end else if (w_load && w_any) begin
      r_own <= 1'b1;
      r_bcnt <= (r_own && w_idx == r_last) ? (w_room ? r_bcnt + 1'b1 : r_bcnt) : '0;
    end
`else
  assign w_idx = w_pidx;
  assign w_any = w_pany;
  assign w_onehot = w_ponehot;
`endif
  assign bus.req_ready = (w_load && !wrst) ? w_onehot : '0;
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      r_win <= 1'b0;
      r_wdata <= '0;
      r_wid <= '0;
      r_last <= IW'(NREQ - 1);
    end else if (w_load) begin
      r_win <= w_any;
      if (w_any) begin
        r_wdata <= bus.req_data[int'(w_idx)*DSIZE +: DSIZE];
        r_wid <= w_idx;
        r_last <= w_idx;
      end
    end
  assign bus.win = r_win;
  assign bus.wdata = r_wdata;
  assign bus.wid = r_wid;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the async FIFO among `NREQ` requesters in the write clock domain. Each requester offers words with a valid/ready handshake; the arbiter selects one per cycle and loads it into an output holding register. That register drives `win`/`wdata` on the FIFO and holds its word until the FIFO accepts it (`win && !wfull`). An optional burst mode keeps a grant on one requester for consecutive beats.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `DSIZE`, 8, data width; matches FIFO `DSIZE`
- `BURST_LEN`, 4, max consecutive beats per grant in burst mode (1..16)
- `wclk`  in  1  write-domain clock; all logic on rising edge
- `wrst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  requester i has a word
- `req_data`  in  NREQ*DSIZE  word of requester i at bits [i*DSIZE +: DSIZE]
- `req_ready`  out  NREQ  one-hot or zero; word i is taken this cycle
- `wfull`  in  1  FIFO full flag (synchronous to `wclk`)
- `win`  out  1  FIFO write enable (registered)
- `wdata`  out  DSIZE  FIFO write data (registered)
- `wid`  out  clog2(NREQ)  index of requester owning the word in `wdata`

## Operation
- Output register state: EMPTY (`win`=0) or HOLD (`win`=1).
- `load = !win | !wfull`. This is true when the register is empty or its word is being accepted this edge.
- Arbitration is combinational and evaluated only when `load`=1.
  - Search `req_valid` starting at `(last+1) mod NREQ`, wrapping; first set bit wins index g.
  - `req_ready[g]=1` and all other bits are 0.
- If `load` and no request: next `win`=0.
- If `load` and grant g: on the edge, `wdata<=req_data[g]`, `wid<=g`, `win<=1`.
- If `!load`: `win`, `wdata`, `wid` hold; `req_ready`=0.
- `last` (clog2(NREQ) bits) updates to g on each accepted beat, or per Configuration.
- `req_ready` never asserts without the matching `req_valid`.
- A word in the register is never dropped or duplicated except on reset.
- Reset values: `win`=0, `wdata`=0, `wid`=0, `last`=NREQ-1 (requester 0 first), burst count 0.
- Reset mid-operation discards the held word. `req_ready`=0 while `wrst`=1.
- `wfull` high with `win`=0: arbitration continues and the register fills once, then holds.

## Timing
- Latency: requester handshake at edge N; `win`=1 with that word in the cycle after edge N.
- Throughput: 1 word/cycle while `wfull`=0. The FIFO accepts and the register reloads in the same edge, with no bubble.
- `wfull` rising while `win`=1: the word holds and no new grant is issued until `wfull` falls.
- `req_ready` depends combinationally on `wfull`, `win` and `req_valid`. It has no combinational path to `req_data`.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - A 4-bit beat counter `bcnt` counts beats granted to `last`.
  - If `req_valid[last]` and `bcnt < BURST_LEN-1`, `last` is re-granted ahead of the round-robin search.
  - Otherwise normal search from `last+1` applies, and `bcnt` resets to 0 on a change of owner.
  - `bcnt` increments only on accepted beats of the same owner.
- Not defined: pure round-robin with no burst logic; `BURST_LEN` is ignored.

## Structure
- Package `fifo_arb_pkg`: `IDW = clog2(NREQ)` helper function and the `BCNT_W` = 4 constant.
- Sub-module `rr_pick`: combinational rotating priority picker.
  - Inputs: `req`, `last`.
  - Outputs: `gnt_onehot`, `gnt_idx`, `any`.
- The top level holds the output register, `last`, `bcnt` and the `load` logic.

## Test plan
- Reset: assert `wrst` with all four `req_valid`=1 → `win`=0, `req_ready`=0. Release → `req_ready`=0001, and `win`=1 with `wid`=0 next cycle.
- Fairness (burst off): all four valid and `wfull`=0 for 8 cycles → `wid` sequence is 0,1,2,3,0,1,2,3, with `wdata` matching each requester's word.
- Backpressure: `wfull`=1 while `win`=1 with word 0xA5 for 5 cycles → `wdata`=0xA5 held and `req_ready`=0. `wfull` falls → 0xA5 accepted and the next grant loads in the same edge.
- Sparse/wrap: only requester 3 valid, then only requester 0 → grants 3 then 0. No idle cycle between them beyond handshake timing.
- Burst (`FIFO_ARB_BURST_EN`, `BURST_LEN`=4): all four valid → `wid` sequence is 0,0,0,0,1,1,1,1. If requester 0 drops valid after 2 beats, the grant moves to 1 immediately.
- Mid-operation reset: `wrst` pulse while `win`=1 and `wfull`=1 → `win`=0 asynchronously. After release, requester 0 has priority.
